// File: rtl/event_encoder_8x3_pkg.sv
`default_nettype none
// ============================================================================
// Module  : event_enc_pkg
// Brief   : Shared widths, FSM state type and one-hot helper for the encoder.
// Revision: 1.0 - initial release
// ============================================================================
package event_enc_pkg;

    localparam int N_EV  = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [N_EV-1:0] onehot8(input logic [IDX_W-1:0] idx);
        return {{(N_EV-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_encoder_8x3_if.sv
`default_nettype none
// ============================================================================
// Module  : event_encoder_8x3_if
// Brief   : Event lines in, encoded index with valid/ready handshake out.
// Revision: 1.0 - initial release
// ============================================================================
interface event_encoder_8x3_if import event_enc_pkg::*; ;

    logic [N_EV-1:0]  x;
    logic             ready;
    logic [IDX_W-1:0] y;
    logic             valid;
    logic [N_EV-1:0]  pending;
    logic             ovf;

    modport master (
        output x, ready,
        input  y, valid, pending, ovf
    );

    modport slave (
        input  x, ready,
        output y, valid, pending, ovf
    );

endinterface
`default_nettype wire

// File: rtl/event_encoder_8x3_penc.sv
`default_nettype none
// ============================================================================
// Module  : priority_encoder_4x2
// Brief   : Combinational 4-to-2 priority encoder with any-valid flag.
// Revision: 1.0 - initial release
// ============================================================================
module priority_encoder_4x2 #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  wire logic [3:0] v_i,
    output logic      [1:0] idx_o,
    output logic            any_o
);

    always_comb begin
        any_o = |v_i;
        idx_o = 2'd0;
        if (HIGH_FIRST) begin
            if      (v_i[3]) idx_o = 2'd3;
            else if (v_i[2]) idx_o = 2'd2;
            else if (v_i[1]) idx_o = 2'd1;
            else             idx_o = 2'd0;
        end else begin
            if      (v_i[0]) idx_o = 2'd0;
            else if (v_i[1]) idx_o = 2'd1;
            else if (v_i[2]) idx_o = 2'd2;
            else if (v_i[3]) idx_o = 2'd3;
            else             idx_o = 2'd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/event_encoder_8x3.sv
`default_nettype none
// ============================================================================
// Module  : event_encoder_8x3
// Brief   : Registered 8-to-3 priority encoder, sticky capture, valid/ready out.
// Revision: 1.0 - initial release
// ============================================================================
module event_encoder_8x3
    import event_enc_pkg::*;
#(
    parameter bit              HIGH_FIRST = 1'b1,
    parameter logic [N_EV-1:0] EVENT_MASK = 8'hFF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    event_encoder_8x3_if.slave bus
);

    state_t           r_state_q;
    logic [N_EV-1:0]  r_pending_q;
    logic [IDX_W-1:0] r_y_q;
    logic             r_ovf_q;

    logic [N_EV-1:0]  w_pending_d;
    logic             w_ovf_d;
    logic [N_EV-1:0]  w_set;
    logic [N_EV-1:0]  w_clr;
    logic [N_EV-1:0]  w_enc_in;
    logic             w_ack;
    logic [1:0]       w_nib_idx [2];
    logic [1:0]       w_nib_any;
    logic             w_sel_hi;
    logic             w_any;
    logic [IDX_W-1:0] w_enc;

    // One encoder serves both states: IDLE looks at the whole pending set,
    // HOLD looks at what remains once the presented index is retired.
    always_comb begin
        w_set       = bus.x & EVENT_MASK;
        w_ack       = (r_state_q == HOLD) && bus.ready;
        w_clr       = w_ack ? onehot8(r_y_q) : '0;
        w_pending_d = (r_pending_q & ~w_clr) | w_set;
        w_ovf_d     = r_ovf_q | (|(w_set & r_pending_q & ~w_clr));
        w_enc_in    = (r_state_q == HOLD) ? (r_pending_q & ~onehot8(r_y_q))
                                          : r_pending_q;
    end

    for (genvar g = 0; g < 2; g++) begin : g_nib
        priority_encoder_4x2 #(
            .HIGH_FIRST (HIGH_FIRST)
        ) u_penc (
            .v_i   (w_enc_in[4*g +: 4]),
            .idx_o (w_nib_idx[g]),
            .any_o (w_nib_any[g])
        );
    end

    always_comb begin
        w_sel_hi = HIGH_FIRST ? w_nib_any[1] : !w_nib_any[0];
        w_any    = |w_nib_any;
        w_enc    = w_sel_hi ? {1'b1, w_nib_idx[1]} : {1'b0, w_nib_idx[0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_pending_q <= '0;
            r_y_q       <= '0;
            r_ovf_q     <= 1'b0;
        end else begin
            r_pending_q <= w_pending_d;
            r_ovf_q     <= w_ovf_d;
            case (r_state_q)
                IDLE: begin
                    if (w_any) begin
                        r_y_q     <= w_enc;
                        r_state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.ready) begin
                        if (w_any) r_y_q     <= w_enc;
                        else       r_state_q <= IDLE;
                    end
                end
                default: r_state_q <= IDLE;
            endcase
        end
    end

    assign bus.y       = r_y_q;
    assign bus.valid   = (r_state_q == HOLD);
    assign bus.pending = r_pending_q;
    assign bus.ovf     = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_event_encoder_8x3.sv
`default_nettype none
// ============================================================================
// Module  : tb_event_encoder_8x3
// Brief   : Three encoder variants driven in parallel against a reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_event_encoder_8x3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] x = 8'h00;
    logic       ready = 1'b0;
    bit         chk_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    event_encoder_8x3_if bus0 ();
    event_encoder_8x3_if bus1 ();
    event_encoder_8x3_if bus2 ();

    assign bus0.x = x;  assign bus0.ready = ready;
    assign bus1.x = x;  assign bus1.ready = ready;
    assign bus2.x = x;  assign bus2.ready = ready;

    event_encoder_8x3 #(.HIGH_FIRST(1'b1), .EVENT_MASK(8'hFF)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    event_encoder_8x3 #(.HIGH_FIRST(1'b0), .EVENT_MASK(8'hFF)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    event_encoder_8x3 #(.HIGH_FIRST(1'b1), .EVENT_MASK(8'hFE)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [2:0] d_y   [3];
    logic       d_val [3];
    logic [7:0] d_pend[3];
    logic       d_ovf [3];
    assign d_y[0] = bus0.y; assign d_val[0] = bus0.valid; assign d_pend[0] = bus0.pending; assign d_ovf[0] = bus0.ovf;
    assign d_y[1] = bus1.y; assign d_val[1] = bus1.valid; assign d_pend[1] = bus1.pending; assign d_ovf[1] = bus1.ovf;
    assign d_y[2] = bus2.y; assign d_val[2] = bus2.valid; assign d_pend[2] = bus2.pending; assign d_ovf[2] = bus2.ovf;

    // Reference: pending set as a bit vector, the presented index as an int
    // chosen by scanning for the first set bit in priority order.
    bit         m_hf  [3] = '{1'b1, 1'b0, 1'b1};
    bit   [7:0] m_mask[3] = '{8'hFF, 8'hFF, 8'hFE};
    bit   [7:0] m_pend[3];
    int         m_y   [3];
    bit         m_val [3];
    bit         m_ovf [3];

    function automatic int pick(input bit [7:0] v, input bit hf);
        if (hf) begin
            for (int i = 7; i >= 0; i--) if (v[i]) return i;
        end else begin
            for (int i = 0; i < 8; i++) if (v[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_pend[k] = 8'h00; m_y[k] = 0; m_val[k] = 1'b0; m_ovf[k] = 1'b0;
            end else begin
                bit [7:0] s, c, nxt, rem;
                s   = x & m_mask[k];
                c   = (m_val[k] && ready) ? (8'h01 << m_y[k]) : 8'h00;
                nxt = (m_pend[k] & ~c) | s;
                if ((s & m_pend[k] & ~c) != 0) m_ovf[k] = 1'b1;
                if (!m_val[k]) begin
                    if (m_pend[k] != 0) begin
                        m_y[k] = pick(m_pend[k], m_hf[k]);
                        m_val[k] = 1'b1;
                    end
                end else if (ready) begin
                    rem = m_pend[k] & ~(8'h01 << m_y[k]);
                    if (rem != 0) m_y[k] = pick(rem, m_hf[k]);
                    else          m_val[k] = 1'b0;
                end
                m_pend[k] = nxt;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_valid[%0d]", k), int'(d_val[k]), int'(m_val[k]));
                chk($sformatf("model_pending[%0d]", k), int'(d_pend[k]), int'(m_pend[k]));
                chk($sformatf("model_ovf[%0d]", k), int'(d_ovf[k]), int'(m_ovf[k]));
                if (m_val[k]) chk($sformatf("model_y[%0d]", k), int'(d_y[k]), m_y[k]);
            end
        end
    end

    task automatic drive(input logic [7:0] xv, input logic rv);
        x = xv;
        ready = rv;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        drive(8'hFF, 1'b0);
        chk_en = 1'b1;
        chk("rst_pending", int'(bus0.pending), 'h00);
        chk("rst_valid", int'(bus0.valid), 0);
        chk("rst_y", int'(bus0.y), 0);
        chk("rst_ovf", int'(bus0.ovf), 0);
        rst = 1'b0;

        // single event
        drive(8'h20, 1'b0);
        chk("single_pending", int'(bus0.pending), 'h20);
        chk("single_valid_late", int'(bus0.valid), 0);
        drive(8'h00, 1'b0);
        chk("single_y", int'(bus0.y), 5);
        chk("single_valid", int'(bus0.valid), 1);
        drive(8'h00, 1'b0);
        chk("single_hold_y", int'(bus0.y), 5);
        drive(8'h00, 1'b1);
        chk("single_ack_valid", int'(bus0.valid), 0);
        chk("single_ack_pending", int'(bus0.pending), 'h00);

        // multi-hot drain, both priority orders
        drive(8'h91, 1'b1);
        drive(8'h00, 1'b1);
        chk("drain_hi_0", int'(bus0.y), 7);
        chk("drain_lo_0", int'(bus1.y), 0);
        drive(8'h00, 1'b1);
        chk("drain_hi_1", int'(bus0.y), 4);
        chk("drain_lo_1", int'(bus1.y), 4);
        drive(8'h00, 1'b1);
        chk("drain_hi_2", int'(bus0.y), 0);
        chk("drain_lo_2", int'(bus1.y), 7);
        drive(8'h00, 1'b1);
        chk("drain_hi_done", int'(bus0.valid), 0);
        chk("drain_lo_done", int'(bus1.valid), 0);

        // no preemption
        drive(8'h04, 1'b0);
        drive(8'h00, 1'b0);
        chk("nopre_y", int'(bus0.y), 2);
        drive(8'h80, 1'b0);
        chk("nopre_hold", int'(bus0.y), 2);
        drive(8'h00, 1'b0);
        chk("nopre_hold2", int'(bus0.y), 2);
        drive(8'h00, 1'b1);
        chk("nopre_next", int'(bus0.y), 7);
        drive(8'h00, 1'b1);
        chk("nopre_done", int'(bus0.valid), 0);

        // set wins over clear
        drive(8'h08, 1'b0);
        drive(8'h00, 1'b0);
        chk("race_y", int'(bus0.y), 3);
        drive(8'h08, 1'b1);
        chk("race_pending", int'(bus0.pending), 'h08);
        chk("race_ovf", int'(bus0.ovf), 0);
        drive(8'h00, 1'b0);
        chk("race_repr_y", int'(bus0.y), 3);
        chk("race_repr_valid", int'(bus0.valid), 1);
        drive(8'h00, 1'b1);

        // overflow and mask
        drive(8'h02, 1'b0);
        drive(8'h02, 1'b0);
        chk("ovf_set", int'(bus0.ovf), 1);
        drive(8'h00, 1'b1);
        drive(8'h00, 1'b0);
        chk("ovf_sticky", int'(bus0.ovf), 1);
        drive(8'h01, 1'b0);
        chk("mask_pending", int'(bus2.pending), 'h00);
        chk("mask_unmasked", int'(bus0.pending), 'h01);
        drive(8'h00, 1'b1);
        drive(8'h00, 1'b1);
        drive(8'h00, 1'b1);

        rst = 1'b1;
        drive(8'hFF, 1'b1);
        chk("rst_ovf_clear", int'(bus0.ovf), 0);
        rst = 1'b0;

        // randomized traffic, sparse events, occasional reset
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive(8'($urandom & $urandom & $urandom), 1'($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;
        drive(8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
